// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the req/ack handshake to instruction
// memory, and produces the pc_en/pc_sel/ir_en datapath strobes.
module if_fetch_ctrl #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_en_o,
  output logic              pc_sel_o,
  output logic              ir_en_o,
  output logic [ADDR_W-1:0] jmp_addr_o,
  output logic              if_valid_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] jmp_q, jmp_d;
  logic              valid_q, valid_d;
  logic              pend_q, pend_d;

  logic              req_c, pc_en_c, pc_sel_c, ir_en_c;
  logic              take_redir, load;
  logic [ADDR_W-1:0] new_tgt, redir_tgt;
  logic              redir_act;

  // A live redirect overrides the latched target; bits [1:0] are forced to zero.
  assign new_tgt   = redirect_addr_i & ALIGN_MASK;
  assign redir_tgt = redirect_i ? new_tgt : jmp_q;
  assign redir_act = redirect_i | pend_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    jmp_d      = jmp_q;
    valid_d    = valid_q;
    pend_d     = pend_q;
    req_c      = 1'b0;
    pc_en_c    = 1'b0;
    pc_sel_c   = 1'b0;
    ir_en_c    = 1'b0;
    take_redir = 1'b0;
    load       = 1'b0;

    if (redirect_i) begin
      jmp_d = new_tgt;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_i) begin
          pend_d = 1'b1;
        end
      end
      S_REQ: begin
        // Nothing outstanding: a redirect is applied now and suppresses the request.
        if (redir_act) begin
          take_redir = 1'b1;
        end else if (!stall_i) begin
          req_c = 1'b1;
          if (imem_ack_i) begin
            load = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req_c = 1'b1;
        if (imem_ack_i) begin
          state_d = S_REQ;
          if (redir_act) begin
            take_redir = 1'b1;
          end else if (!stall_i) begin
            load = 1'b1;
          end
        end else if (redirect_i) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take_redir) begin
      pc_en_c  = 1'b1;
      pc_sel_c = 1'b1;
      pc_d     = redir_tgt;
      valid_d  = 1'b0;
      pend_d   = 1'b0;
    end

    if (load) begin
      ir_en_c = 1'b1;
      pc_en_c = 1'b1;
      pc_d    = pc_q + STEP;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      jmp_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      jmp_q   <= jmp_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  // Strobes are quiet while reset is held.
  assign imem_req_o  = req_c & ~rst;
  assign pc_en_o     = pc_en_c & ~rst;
  assign pc_sel_o    = pc_sel_c & ~rst;
  assign ir_en_o     = ir_en_c & ~rst;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign jmp_addr_o  = jmp_q;
  assign if_valid_o  = valid_q;

endmodule
